// File: rtl/hack_alu_if.sv
// Operand/control and result bundle between the datapath and the Hack ALU.
interface hack_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no,
    input  out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no,
    output out_valid, out, zr, ng
  );
endinterface

// File: rtl/hack_alu.sv
// Registered Hack-style ALU: one result per accepted operand set, one cycle of latency.
module hack_alu #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  hack_alu_if.slave bus
);

  // ctrl_v packs {zx, nx, zy, ny, f, no}; carry-out of the add is intentionally dropped.
  function automatic logic [WIDTH-1:0] alu_core(
    input logic [WIDTH-1:0] x_v,
    input logic [WIDTH-1:0] y_v,
    input logic [5:0]       ctrl_v
  );
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] r;
    xa = ctrl_v[5] ? {WIDTH{1'b0}} : x_v;
    xb = ctrl_v[4] ? ~xa : xa;
    ya = ctrl_v[3] ? {WIDTH{1'b0}} : y_v;
    yb = ctrl_v[2] ? ~ya : ya;
    r  = ctrl_v[1] ? (xb + yb) : (xb & yb);
    return ctrl_v[0] ? ~r : r;
  endfunction

  logic [WIDTH-1:0] res_s;
  logic             zr_s;
  logic             ng_s;
  logic [WIDTH-1:0] out_r;
  logic             zr_r;
  logic             ng_r;
  logic             out_valid_r;

  // Combinational datapath and flag derivation.
  always_comb begin
    res_s = alu_core(bus.x, bus.y, {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
    zr_s  = (res_s == {WIDTH{1'b0}});
    ng_s  = res_s[WIDTH-1];
  end

  // Result register: reset wins, valid loads, otherwise hold data and drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= {WIDTH{1'b0}};
      zr_r        <= 1'b1;
      ng_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      out_r       <= res_s;
      zr_r        <= zr_s;
      ng_r        <= ng_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out       = out_r;
  assign bus.zr        = zr_r;
  assign bus.ng        = ng_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_hack_alu.sv
// Directed and randomised self-checking bench for the 8-bit Hack ALU.
module tb_hack_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  hack_alu_if #(.WIDTH(8)) bus ();

  hack_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic v);
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
    bus.x        = a;
    bus.y        = b;
    bus.in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic reference; returns {zr, ng, out}.
  function automatic logic [9:0] model(input logic [5:0] c, input logic [7:0] a,
                                       input logic [7:0] b);
    int xi;
    int yi;
    int ri;
    logic [7:0] rb;
    xi = c[5] ? 0 : int'(a);
    if (c[4]) xi = 255 - xi;
    yi = c[3] ? 0 : int'(b);
    if (c[2]) yi = 255 - yi;
    ri = c[1] ? ((xi + yi) % 256) : (xi & yi);
    if (c[0]) ri = 255 - ri;
    rb = ri[7:0];
    return {(ri == 0), (ri >= 128), rb};
  endfunction

  task automatic test_reset();
    drive(6'b000010, 8'd17, 8'd6, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
        nerr++;
        $display("FAIL reset[%0d] ov/zr/ng/out=%b/%b/%b/%h want 0/1/0/00", i,
                 bus.out_valid, bus.zr, bus.ng, bus.out);
      end
    end
    rst = 1'b0;
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b0, 1'b0, 8'd23}) begin
      nerr++;
      $display("FAIL first_after_reset ov/zr/ng/out=%b/%b/%b/%h want 1/0/0/17",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
    drive(6'b000010, 8'd1, 8'd2, 1'b1);
    rst = 1'b1;
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL midstream_reset ov/zr/ng/out=%b/%b/%b/%h want 0/1/0/00",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL idle_after_reset ov/zr/ng/out=%b/%b/%b/%h want 0/1/0/00",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
  endtask

  task automatic test_constants();
    logic [5:0] c [0:4];
    logic [7:0] e [0:4];
    logic       ez [0:4];
    logic       en [0:4];
    c  = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000};
    e  = '{8'd0, 8'd1, 8'hFF, 8'd17, 8'd6};
    ez = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    en = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(c[i], 8'd17, 8'd6, 1'b1);
      step();
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, ez[i], en[i], e[i]}) begin
        nerr++;
        $display("FAIL const[%0d] ctrl=%b ov/zr/ng/out=%b/%b/%b/%h want 1/%b/%b/%h", i, c[i],
                 bus.out_valid, bus.zr, bus.ng, bus.out, ez[i], en[i], e[i]);
      end
    end
  endtask

  task automatic test_negations();
    logic [5:0] c [0:7];
    logic [7:0] e [0:7];
    logic       en [0:7];
    c  = '{6'b001101, 6'b110001, 6'b001111, 6'b110011,
           6'b011111, 6'b110111, 6'b001110, 6'b110010};
    e  = '{8'hEE, 8'hF9, 8'hEF, 8'hFA, 8'd18, 8'd7, 8'd16, 8'd5};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(c[i], 8'd17, 8'd6, 1'b1);
      step();
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b0, en[i], e[i]}) begin
        nerr++;
        $display("FAIL neg_inc[%0d] ctrl=%b ov/zr/ng/out=%b/%b/%b/%h want 1/0/%b/%h", i, c[i],
                 bus.out_valid, bus.zr, bus.ng, bus.out, en[i], e[i]);
      end
    end
  endtask

  task automatic test_two_operand();
    logic [5:0] c [0:3];
    logic [7:0] e [0:3];
    logic       ez [0:3];
    logic       en [0:3];
    c  = '{6'b010011, 6'b000111, 6'b000000, 6'b010101};
    e  = '{8'd11, 8'hF5, 8'd0, 8'd23};
    ez = '{1'b0, 1'b0, 1'b1, 1'b0};
    en = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(c[i], 8'd17, 8'd6, 1'b1);
      step();
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, ez[i], en[i], e[i]}) begin
        nerr++;
        $display("FAIL two_op[%0d] ctrl=%b ov/zr/ng/out=%b/%b/%b/%h want 1/%b/%b/%h", i, c[i],
                 bus.out_valid, bus.zr, bus.ng, bus.out, ez[i], en[i], e[i]);
      end
    end
  endtask

  task automatic test_wrap();
    drive(6'b000010, 8'hFF, 8'h01, 1'b1);
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL wrap_add ov/zr/ng/out=%b/%b/%b/%h want 1/1/0/00",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
    drive(6'b001111, 8'h80, 8'h01, 1'b1);
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b0, 1'b1, 8'h80}) begin
      nerr++;
      $display("FAIL neg_min ov/zr/ng/out=%b/%b/%b/%h want 1/0/1/80",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
    drive(6'b001111, 8'h00, 8'h05, 1'b1);
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL neg_zero ov/zr/ng/out=%b/%b/%b/%h want 1/1/0/00",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
  endtask

  task automatic test_hold();
    drive(6'b000010, 8'd17, 8'd6, 1'b1);
    step();
    nvec++;
    if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b1, 1'b0, 1'b0, 8'd23}) begin
      nerr++;
      $display("FAIL hold_issue ov/zr/ng/out=%b/%b/%b/%h want 1/0/0/17",
               bus.out_valid, bus.zr, bus.ng, bus.out);
    end
    drive(6'b111010, 8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== {1'b0, 1'b0, 1'b0, 8'd23}) begin
        nerr++;
        $display("FAIL hold[%0d] ov/zr/ng/out=%b/%b/%b/%h want 0/0/0/17", i,
                 bus.out_valid, bus.zr, bus.ng, bus.out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_s;
    logic [5:0]  c;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        v;
    exp_s = {1'b0, 1'b0, 1'b0, 8'd23};
    for (int i = 0; i < 60; i++) begin
      c = 6'($urandom_range(0, 63));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      v = (i < 30) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(c, a, b, v);
      step();
      if (v) exp_s = {1'b1, model(c, a, b)};
      else   exp_s = {1'b0, exp_s[9:0]};
      nvec++;
      if ({bus.out_valid, bus.zr, bus.ng, bus.out} !== exp_s) begin
        nerr++;
        $display("FAIL rand[%0d] ctrl=%b x=%h y=%h v=%b ov/zr/ng/out=%b/%b/%b/%h want %b/%b/%b/%h",
                 i, c, a, b, v, bus.out_valid, bus.zr, bus.ng, bus.out,
                 exp_s[10], exp_s[9], exp_s[8], exp_s[7:0]);
      end
    end
  endtask

  initial begin
    drive(6'b000000, 8'd0, 8'd0, 1'b0);
    test_reset();
    test_constants();
    test_negations();
    test_two_operand();
    test_wrap();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hack_alu.md
Name: hack_alu

Overview:
- Registered Hack-style ALU of parameterisable width, 8 bits by default.
- Computes one of the Hack function set from two operands x and y, using six control bits: zx, nx, zy, ny, f, no.
- Also produces a zero flag (zr) and a negative flag (ng).
- Sits in the CPU datapath between the register file/A-D registers and the writeback mux; result is available one clock after operands are presented.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/controls valid this cycle; sampled on rising edge
- x  input  WIDTH  operand X (two's complement)
- y  input  WIDTH  operand Y (two's complement)
- zx  input  1  zero X
- nx  input  1  bitwise-negate X (applied after zx)
- zy  input  1  zero Y
- ny  input  1  bitwise-negate Y (applied after zy)
- f  input  1  function select: 1 = add, 0 = bitwise AND
- no  input  1  bitwise-negate result
- out_valid  output  1  out/zr/ng hold a new result
- out  output  WIDTH  result
- zr  output  1  1 when out == 0
- ng  output  1  1 when out is negative, i.e. out[WIDTH-1]

Behaviour:
- Combinational core, in order:
  - xa = zx ? 0 : x
  - xb = nx ? ~xa : xa
  - ya = zy ? 0 : y
  - yb = ny ? ~ya : ya
  - r = f ? (xb + yb) mod 2^WIDTH : (xb & yb). Carry-out is discarded; there is no overflow flag.
  - res = no ? ~r : r
- Flags are derived from res: zr = (res == 0), ng = res[WIDTH-1].
- Registration and latency:
  - On a rising clk with rst=0 and in_valid=1, out/zr/ng load res and its flags, and out_valid goes to 1. Latency is exactly 1 cycle.
  - On a rising clk with rst=0 and in_valid=0: out, zr and ng hold their previous values; out_valid goes to 0.
  - Back-to-back operation: a new operation may be issued every cycle. There is no stall and no backpressure.
- Reset (synchronous, priority over in_valid): out=0, zr=1, ng=0, out_valid=0.
  - Reset asserted mid-stream discards the in-flight sample.
  - The first valid result after reset deassertion appears one cycle after the first in_valid=1 edge.
- Control encodings (Hack set) that must produce the listed result:
  - 101010 -> 0
  - 111111 -> 1
  - 111010 -> -1
  - 001100 -> x
  - 110000 -> y
  - 001101 -> ~x
  - 110001 -> ~y
  - 001111 -> -x
  - 110011 -> -y
  - 011111 -> x+1
  - 110111 -> y+1
  - 001110 -> x-1
  - 110010 -> y-1
  - 000010 -> x+y
  - 010011 -> x-y
  - 000111 -> y-x
  - 000000 -> x&y
  - 010101 -> x|y
- All 64 control combinations are legal and follow the datapath above; non-Hack codes are not special-cased.
- Arithmetic wrap-around: x+y beyond 2^WIDTH-1 wraps; -0 = 0; -(100..0) = 100..0 with ng=1.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out=0, zr=1, ng=0, out_valid=0. Release, then issue x+y with x=17, y=6 -> next cycle out=23, out_valid=1.
- Constants and passthrough, x=17 (00010001), y=6 (00000110), one op per cycle:
  - 0 -> 0, zr=1
  - 1 -> 1
  - -1 -> 0xFF, ng=1
  - x -> 17
  - y -> 6
- Negations and increments, same operands:
  - ~x -> 0xEE, ng=1
  - ~y -> 0xF9
  - -x -> 0xEF
  - -y -> 0xFA
  - x+1 -> 18
  - y+1 -> 7
  - x-1 -> 16
  - y-1 -> 5
- Two-operand ops, same operands:
  - x-y -> 11
  - y-x -> 0xF5, ng=1
  - x&y -> 0, zr=1
  - x|y -> 23
- Wrap and sign: x=0xFF, y=0x01, x+y -> 0x00, zr=1. x=0x80, -x -> 0x80, ng=1.
- Hold and pipeline: issue x+y, then drop in_valid for 3 cycles -> out stays 23 and out_valid=0 after the first hold cycle. Random controls and operands every cycle must match a reference model delayed by 1 cycle.
